// File: rtl/mandel_cfg_loader_if.sv
// Host-side config word handshake for mandel_cfg_loader.
// The host drives a word with valid; the loader answers with ready from its pending slot.
interface mandel_cfg_loader_if #(
    parameter int CFG_BITS = 33
) ();
    logic [CFG_BITS-1:0] cfg_data;
    logic                cfg_valid;
    logic                cfg_ready;

    modport master (
        output cfg_data,
        output cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_data,
        input  cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/mandel_cfg_loader.sv
// Serial config loader for the tinymandelbrot core: shifts DEFAULT_CFG after reset,
// then host words, LSB-first with HALF_PERIOD clk cycles per sclk phase.
module mandel_cfg_loader #(
    parameter int                  CFG_BITS    = 33,
    parameter logic [CFG_BITS-1:0] DEFAULT_CFG = 33'h03CF10404,
    parameter int                  HALF_PERIOD = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    mandel_cfg_loader_if.slave    host,
    output logic                  cfg_en,
    output logic                  cfg_sdata,
    output logic                  cfg_sclk,
    output logic                  busy,
    output logic                  done,
    output logic                  loaded
);
    localparam int CNT_W = $clog2(CFG_BITS + 1);
    localparam int PH_W  = $clog2(HALF_PERIOD + 1);

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, FINISH} state_t;

    state_t              state_q, state_d;
    logic [CFG_BITS-1:0] pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic [CFG_BITS-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
    logic [PH_W-1:0]     phase_q, phase_d;
    logic                cfg_en_q, cfg_en_d;
    logic                cfg_sclk_q, cfg_sclk_d;
    logic                cfg_sdata_q, cfg_sdata_d;
    logic                done_q, done_d;
    logic                loaded_q, loaded_d;
    logic                phase_last;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        shreg_d      = shreg_q;
        bitcnt_d     = bitcnt_q;
        phase_d      = '0;
        phase_last   = (phase_q == PH_W'(HALF_PERIOD - 1));

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    shreg_d      = pend_q;
                    pend_valid_d = 1'b0;
                    bitcnt_d     = '0;
                    state_d      = SETUP;
                end
            end
            SETUP: begin
                if (phase_last) state_d = HIGH;
                else            phase_d = phase_q + PH_W'(1);
            end
            HIGH: begin
                // Data advances only as sclk falls, so it is stable across the whole high phase.
                if (phase_last) begin
                    shreg_d  = shreg_q >> 1;
                    bitcnt_d = bitcnt_q + CNT_W'(1);
                    state_d  = (bitcnt_d == CNT_W'(CFG_BITS)) ? FINISH : LOW;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            LOW: begin
                if (phase_last) state_d = HIGH;
                else            phase_d = phase_q + PH_W'(1);
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (host.cfg_valid && !pend_valid_q) begin
            pend_d       = host.cfg_data;
            pend_valid_d = 1'b1;
        end

        // Outputs are registered from the next state so they line up with state_q.
        cfg_en_d    = (state_d == SETUP) || (state_d == HIGH) || (state_d == LOW);
        cfg_sclk_d  = (state_d == HIGH);
        cfg_sdata_d = cfg_en_d & shreg_d[0];
        done_d      = (state_d == FINISH);
        loaded_d    = loaded_q | done_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pend_q       <= DEFAULT_CFG;
            pend_valid_q <= 1'b1;
            shreg_q      <= '0;
            bitcnt_q     <= '0;
            phase_q      <= '0;
            cfg_en_q     <= 1'b0;
            cfg_sclk_q   <= 1'b0;
            cfg_sdata_q  <= 1'b0;
            done_q       <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            shreg_q      <= shreg_d;
            bitcnt_q     <= bitcnt_d;
            phase_q      <= phase_d;
            cfg_en_q     <= cfg_en_d;
            cfg_sclk_q   <= cfg_sclk_d;
            cfg_sdata_q  <= cfg_sdata_d;
            done_q       <= done_d;
            loaded_q     <= loaded_d;
        end
    end

    assign host.cfg_ready = ~pend_valid_q;
    assign busy           = (state_q != IDLE) | pend_valid_q;
    assign cfg_en         = cfg_en_q;
    assign cfg_sclk       = cfg_sclk_q;
    assign cfg_sdata      = cfg_sdata_q;
    assign done           = done_q;
    assign loaded         = loaded_q;
endmodule
